fetch_unit: RTL
===============

# fetch_unit

Front-end fetch stage, directly upstream of the instruction memory. It owns the program counter, drives the PC into the combinational instruction memory, and captures the returned word with its PC into a small in-order fetch queue. Decode drains the queue through a valid/ready handshake. A branch/exception redirect flushes the queue and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000: fetch address loaded on reset.
- DEPTH, 4: fetch-queue entries; power of two, at least 2.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_pc  out  32  address to instruction memory; equals the internal fetch_pc register.
- imem_instr  in  32  instruction word returned combinationally for imem_pc in the same cycle.
- redirect_valid  in  1  flush queue and restart fetch.
- redirect_pc  in  32  new fetch address; sampled when redirect_valid=1.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at queue head.
- out_pc  out  32  PC of queue head.
- count  out  log2(DEPTH)+1  current queue occupancy, 0..DEPTH.

## Operation
- State: fetch_pc (32 b), DEPTH-entry storage of {pc, instr}, head and tail pointers (log2(DEPTH) b, wrap modulo DEPTH), and count.
- deq = out_valid & out_ready.
- enq = !redirect_valid & ((count < DEPTH) | deq).
- On enq: storage[tail] <= {fetch_pc, imem_instr}; tail advances by 1; fetch_pc <= fetch_pc + 4.
  - The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - The low 2 bits of fetch_pc are carried unchanged.
- On deq: head advances by 1.
- count update: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
- Full (count=DEPTH) with no deq: no enq, and fetch_pc holds.
- Full with deq: enq and deq occur in the same cycle, so full throughput is sustained and count stays DEPTH.
- Empty (count=0): out_valid=0 and out_ready is ignored.
- Redirect has priority over everything:
  - head, tail and count go to 0, and fetch_pc <= redirect_pc.
  - No enq occurs that cycle.
  - A deq handshake in the same cycle completes from decode's point of view; decode is responsible for squashing it.
- out_valid = (count != 0). out_instr and out_pc are storage[head]. All three are functions of registered state only, with no combinational path from inputs.
- Reset:
  - fetch_pc = RESET_PC, so imem_pc = RESET_PC.
  - head, tail and count = 0; out_valid = 0.
  - All storage entries are cleared to 0, so out_instr = 0 and out_pc = 0.
  - Reset overrides redirect_valid and any handshake in the same cycle.
  - Reset asserted mid-stream discards all queued entries.

## Timing
- Fetch-to-output latency is 1 cycle. A word presented on imem_instr in cycle N, with enq=1, appears at the head in cycle N+1 if the queue was empty.
- After rst deasserts in cycle 0, the RESET_PC word is enqueued in cycle 0. In cycle 1, out_valid=1, out_pc=RESET_PC and imem_pc=RESET_PC+4.
- Steady state with out_ready held at 1: one instruction per cycle, and count stays at 1.
- Redirect in cycle N:
  - Cycle N+1: imem_pc=redirect_pc, out_valid=0.
  - Cycle N+2: out_valid=1, out_pc=redirect_pc.
- Back-to-back redirects: the last one wins, and each restarts the 2-cycle refill.

## Test plan
- Reset/fill: RESET_PC=0x100, memory holds word i = 0xA000_0000+i, out_ready=0 → after 4 cycles count=4 and imem_pc=0x110 holds; the head shows pc=0x100, instr=mem[0x100>>2].
- Drain in order: from the full state, hold out_ready=1 → one entry per cycle, out_pc=0x100,0x104,0x108,…; count stays 4 (simultaneous enq and deq).
- Redirect mid-stream: with count=3, pulse redirect_valid with redirect_pc=0x40 and out_ready=1 → next cycle count=0, out_valid=0, imem_pc=0x40; the cycle after, out_pc=0x40.
- Wrap-around: RESET_PC=0xFFFF_FFF8, out_ready=1 → out_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; queue pointers wrap across more than 2*DEPTH transfers with no loss or duplication.
- Random stall: out_ready pseudo-random for 1000 cycles → the out_pc stream is strictly +4 consecutive between redirects, count never exceeds DEPTH, and out_valid=0 exactly when count=0.
- Reset mid-operation: assert rst with count=2 and redirect_valid=1 → next cycle count=0, imem_pc=RESET_PC, out_pc=0, out_instr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage.
// Owns the program counter, presents it to a combinational instruction
// memory and captures {pc, instr} into a small in-order queue that decode
// drains with a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at a new address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_pc,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];

  logic deq;
  logic enq;

  // Handshake decode: a full queue may still accept a new word when the head
  // leaves in the same cycle, which keeps throughput at one word per cycle.
  always_comb begin
    deq = (count_q != '0) & out_ready;
    enq = ~redirect_valid & ((count_q != FULL_COUNT) | deq);
  end

  // Next-state for PC, pointers, occupancy and storage; redirect wins over
  // both enqueue and the occupancy bookkeeping of a same-cycle dequeue.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (enq) begin
      pc_mem_d[tail_q]    = fetch_pc_q;
      instr_mem_d[tail_q] = imem_instr;
      tail_d              = tail_q + PTR_W'(1);
      fetch_pc_d          = fetch_pc_q + 32'd4;
    end

    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end
  end

  // State registers; reset clears every storage entry so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  // Outputs come straight from registered state; no input reaches them.
  always_comb begin
    imem_pc   = fetch_pc_q;
    out_valid = (count_q != '0);
    out_pc    = pc_mem_q[head_q];
    out_instr = instr_mem_q[head_q];
    count     = count_q;
  end

endmodule
